// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_adder_pkg;

    // Controller states; encodings are fixed so they can be read directly in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from gate primitives; the one arithmetic cell of the serial adder.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    output wire sum,
    output wire cout,
    input  wire a,
    input  wire b,
    input  wire cin
);

    wire w_axb;
    wire w_ab;
    wire w_cx;

    xor g_x0 (w_axb, a, b);
    xor g_x1 (sum, w_axb, cin);
    and g_a0 (w_ab, a, b);
    and g_a1 (w_cx, w_axb, cin);
    or  g_o0 (cout, w_ab, w_cx);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout,sum} = a + b + cin, one bit per clock through one full-adder cell.
// Latency: done pulses WIDTH edges after the accepting edge; result registers hold until the next completion.
// Backpressure: start is accepted only in IDLE or DONE; a start while running is dropped, not queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for tiny widths.
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    wire              w_sum;
    wire              w_cout;

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    // The only arithmetic: LSBs of both operand shifters plus the carry flop.
    full_adder u_fa (
        .sum  (w_sum),
        .cout (w_cout),
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry)
    );

    // Controller, operand/result shifters, carry flop and bit counter in one registered FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves like IDLE for acceptance, which gives back-to-back operation.
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // Sum bit enters at the MSB so the first bit lands at bit 0 after WIDTH shifts.
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // Publish directly from the final shift so the result appears with done.
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= {w_sum, r_res[WIDTH-1:1]};
                        r_cout  <= w_cout;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
